uart_rx_8n1: RTL and testbench

- Serial receiver for the 8N1 async link driven by the team's transmitter: idle-high line, one start bit (0), 8 data bits LSB first, one stop bit (1).
- Oversamples the line 16x with an internal tick divider from CLOCK_50, validates start and stop, and presents each received byte in parallel with a one-cycle strobe.
- Sits at the board RX pin; it feeds the character consumer and is the loopback partner of the transmitter.

---
 rtl/uart_rx_8n1_if.sv | 22 ++
 rtl/uart_rx_8n1.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Receiver-side signal bundle for uart_rx_8n1: serial line in, framed byte and strobes out.
// charReceived/frameError are valid-only strobes (no ready); DataOut holds until the next good frame.
interface uart_rx_8n1_if #(
   parameter int DATA_BITS = 8
);
   logic                 DataIn;
   logic [DATA_BITS-1:0] DataOut;
   logic                 charReceived;
   logic                 frameError;
   logic                 busy;
   logic [2:0]           state_dbg;

   modport master (
      input  DataIn,
      output DataOut, charReceived, frameError, busy, state_dbg
   );

   modport slave (
      output DataIn,
      input  DataOut, charReceived, frameError, busy, state_dbg
   );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver, 16x oversampled from a free-running tick divider.
// Optional macro RX_MAJORITY_EN: each bit decision is a 3-tick majority vote.
module uart_rx_8n1 #(
   parameter int CLKS_PER_TICK = 301,
   parameter int OVERSAMPLE    = 16,
   parameter int DATA_BITS     = 8
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   uart_rx_8n1_if.master rx_if
);
   localparam int DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam int SC_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLKS_PER_TICK - 1);
   localparam logic [SC_W-1:0]  SC_LAST      = SC_W'(OVERSAMPLE - 1);
   localparam logic [SC_W-1:0]  SC_MID_START = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [SC_W-1:0]      sc_q, sc_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 char_q, char_d;
   logic                 ferr_q, ferr_d;

   logic tick;
   logic rx_s;
   logic bit_val;

   assign rx_s = sync2_q;
   assign tick = (div_q == DIV_LAST);

   always_comb begin
      sync1_d = rx_if.DataIn;
      sync2_d = sync1_q;
      div_d   = tick ? '0 : div_q + 1'b1;
   end

`ifdef RX_MAJORITY_EN
   localparam logic [SC_W-1:0] SC_START_A = SC_MID_START - SC_W'(2);
   localparam logic [SC_W-1:0] SC_START_B = SC_MID_START - SC_W'(1);
   localparam logic [SC_W-1:0] SC_BIT_A   = SC_LAST - SC_W'(2);
   localparam logic [SC_W-1:0] SC_BIT_B   = SC_LAST - SC_W'(1);

   logic maj_a_q, maj_a_d;
   logic maj_b_q, maj_b_d;

   // The two earlier votes are captured on the ticks just before the decision tick.
   always_comb begin
      maj_a_d = maj_a_q;
      maj_b_d = maj_b_q;
      if (tick) begin
         if (state_q == START) begin
            if (sc_q == SC_START_A) maj_a_d = rx_s;
            if (sc_q == SC_START_B) maj_b_d = rx_s;
         end else if (state_q == DATA || state_q == STOP) begin
            if (sc_q == SC_BIT_A) maj_a_d = rx_s;
            if (sc_q == SC_BIT_B) maj_b_d = rx_s;
         end
      end
      bit_val = (maj_a_q & maj_b_q) | (maj_a_q & rx_s) | (maj_b_q & rx_s);
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         maj_a_q <= 1'b1;
         maj_b_q <= 1'b1;
      end else begin
         maj_a_q <= maj_a_d;
         maj_b_q <= maj_b_d;
      end
   end
`else
   always_comb begin
      bit_val = rx_s;
   end
`endif

   // IDLE pins sc at 0, so the tick that sees the start edge counts as sc=0.
   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      char_d  = 1'b0;
      ferr_d  = 1'b0;
      if (state_q == WAIT_IDLE) begin
         if (rx_s) begin
            state_d = IDLE;
            sc_d    = '0;
         end else if (tick) begin
            sc_d = sc_q + 1'b1;
         end
      end else if (tick) begin
         sc_d = sc_q + 1'b1;
         unique case (state_q)
            IDLE: begin
               if (!rx_s) state_d = START;
               else       sc_d    = '0;
            end
            START: begin
               if (sc_q == SC_MID_START) begin
                  sc_d  = '0;
                  bit_d = '0;
                  if (!bit_val) state_d = DATA;
                  else          state_d = IDLE;
               end
            end
            DATA: begin
               if (sc_q == SC_LAST) begin
                  shift_d[bit_q] = bit_val;
                  if (bit_q == BIT_LAST) state_d = STOP;
                  else                   bit_d   = bit_q + 1'b1;
               end
            end
            STOP: begin
               if (sc_q == SC_LAST) begin
                  if (bit_val) begin
                     data_d  = shift_q;
                     char_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = WAIT_IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         div_q   <= '0;
         sc_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         char_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         div_q   <= div_d;
         sc_q    <= sc_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         char_q  <= char_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_if.DataOut      = data_q;
   assign rx_if.charReceived = char_q;
   assign rx_if.frameError   = ferr_q;
   assign rx_if.busy         = (state_q != IDLE);
   assign rx_if.state_dbg    = state_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Randomized bench for uart_rx_8n1: tick-aligned line waveforms decoded by a mid-bit reference model.
module tb_uart_rx_8n1;
   localparam int CPT = 4;
   localparam int TPB = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_8n1_if rx_if ();

   uart_rx_8n1 #(.CLKS_PER_TICK(CPT)) dut (
      .CLOCK_50 (clk),
      .reset    (rst_n),
      .rx_if    (rx_if.master)
   );

   int vectors     = 0;
   int miscompares = 0;
   int rx_cnt      = 0;
   int fe_cnt      = 0;

   logic       wave_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   // Monitor: collects received bytes and strobe counts, and flags overlapping strobes.
   always @(negedge clk) begin
      if (rx_if.charReceived === 1'b1) begin
         got_q.push_back(rx_if.DataOut);
         rx_cnt++;
      end
      if (rx_if.frameError === 1'b1) fe_cnt++;
      if (rx_if.charReceived === 1'b1 && rx_if.frameError === 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL strobe_overlap: charReceived and frameError both 1, required at most one");
      end
   end

   // Reference: a bit is its line level at tick 7 of its 16 ticks (majority of ticks 5..7 if enabled).
   function automatic logic [7:0] model_byte(input logic [7:0] d, input int gseg);
      logic [7:0] r;
      logic s5, s6, s7;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         s5 = d[j] ^ (gseg == 5);
         s6 = d[j] ^ (gseg == 6);
         s7 = d[j] ^ (gseg == 7);
`ifdef RX_MAJORITY_EN
         r[j] = (s5 & s6) | (s5 & s7) | (s6 & s7);
`else
         r[j] = s7;
`endif
      end
      return r;
   endfunction

   function automatic void push_level(input logic lvl, input int n);
      for (int t = 0; t < n; t++) wave_q.push_back(lvl);
   endfunction

   function automatic void push_frame(input logic [7:0] d, input logic stop, input int gseg);
      push_level(1'b0, TPB);
      for (int j = 0; j < 8; j++)
         for (int t = 0; t < TPB; t++) wave_q.push_back(d[j] ^ (t == gseg));
      push_level(stop, TPB);
   endfunction

   task automatic play_n(input int n);
      for (int i = 0; i < n && wave_q.size() > 0; i++) begin
         rx_if.DataIn = wave_q.pop_front();
         repeat (CPT) @(posedge clk);
         #1;
      end
   endtask

   task automatic play_all();
      play_n(wave_q.size());
   endtask

   task automatic idle_ticks(input int n);
      rx_if.DataIn = 1'b1;
      repeat (n * CPT) @(posedge clk);
      #1;
   endtask

   // Release lands just before a rising edge so the bench's tick phase matches the divider.
   task automatic apply_reset(input int cycles);
      rst_n        = 1'b0;
      rx_if.DataIn = 1'b1;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (CPT) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset(3);
      vectors++;
      if (rx_if.DataOut !== 8'h00) begin
         miscompares++; $display("FAIL reset_dataout: got %h, required 00", rx_if.DataOut);
      end
      vectors++;
      if (rx_if.charReceived !== 1'b0) begin
         miscompares++; $display("FAIL reset_char: got %b, required 0", rx_if.charReceived);
      end
      vectors++;
      if (rx_if.frameError !== 1'b0) begin
         miscompares++; $display("FAIL reset_ferr: got %b, required 0", rx_if.frameError);
      end
      vectors++;
      if (rx_if.busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_busy: got %b, required 0", rx_if.busy);
      end
      idle_ticks(4);
   endtask

   task automatic test_basic();
      int rx0, fe0;
      logic [7:0] g;
      rx0 = rx_cnt; fe0 = fe_cnt;
      push_frame(8'hA5, 1'b1, -1);
      play_all();
      idle_ticks(1);
      vectors++;
      if (rx_cnt - rx0 !== 1) begin
         miscompares++; $display("FAIL basic_count: got %0d pulses, required 1", rx_cnt - rx0);
      end
      vectors++;
      if (fe_cnt - fe0 !== 0) begin
         miscompares++; $display("FAIL basic_ferr: got %0d, required 0", fe_cnt - fe0);
      end
      vectors++;
      if (rx_if.DataOut !== 8'hA5) begin
         miscompares++; $display("FAIL basic_dataout: got %h, required a5", rx_if.DataOut);
      end
      vectors++;
      if (rx_if.busy !== 1'b0) begin
         miscompares++; $display("FAIL basic_busy: got %b, required 0", rx_if.busy);
      end
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++;
      if (g !== 8'hA5) begin
         miscompares++; $display("FAIL basic_byte: got %h, required a5", g);
      end
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      int rx0, n, gseg;
      logic [7:0] d, g, last;
      rx0 = rx_cnt;
      got_q.delete();
      exp_q.delete();
      push_frame(8'h00, 1'b1, -1); exp_q.push_back(8'h00);
      push_frame(8'hFF, 1'b1, -1); exp_q.push_back(8'hFF);
      last = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         d    = 8'($urandom_range(0, 255));
         gseg = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(10, 15);
         push_level(1'b1, TPB * $urandom_range(0, 2));
         push_frame(d, 1'b1, gseg);
         exp_q.push_back(model_byte(d, gseg));
         last = model_byte(d, gseg);
      end
      n = exp_q.size();
      play_all();
      idle_ticks(2);
      vectors++;
      if (rx_cnt - rx0 !== n) begin
         miscompares++; $display("FAIL b2b_count: got %0d pulses, required %0d", rx_cnt - rx0, n);
      end
      while (exp_q.size() > 0) begin
         d = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         vectors++;
         if (g !== d) begin
            miscompares++; $display("FAIL b2b_byte: got %h, required %h", g, d);
         end
      end
      vectors++;
      if (rx_if.DataOut !== last) begin
         miscompares++; $display("FAIL b2b_last: got %h, required %h", rx_if.DataOut, last);
      end
      got_q.delete();
   endtask

   task automatic test_false_start();
      int rx0, fe0;
      rx0 = rx_cnt; fe0 = fe_cnt;
      push_level(1'b0, 5);
      play_all();
      vectors++;
      if (rx_if.busy !== 1'b1) begin
         miscompares++; $display("FAIL fstart_busy_hi: got %b, required 1", rx_if.busy);
      end
      idle_ticks(6);
      vectors++;
      if (rx_if.busy !== 1'b0) begin
         miscompares++; $display("FAIL fstart_busy_lo: got %b, required 0", rx_if.busy);
      end
      vectors++;
      if ((rx_cnt - rx0) !== 0 || (fe_cnt - fe0) !== 0) begin
         miscompares++;
         $display("FAIL fstart_pulses: got %0d char / %0d ferr, required 0 / 0", rx_cnt - rx0, fe_cnt - fe0);
      end
      idle_ticks(TPB);
   endtask

   task automatic test_frame_error();
      int rx0, fe0;
      rx0 = rx_cnt; fe0 = fe_cnt;
      got_q.delete();
      push_frame(8'h5A, 1'b1, -1);
      push_level(1'b1, TPB);
      push_frame(8'h3C, 1'b0, -1);
      push_level(1'b0, 8);
      play_all();
      vectors++;
      if (fe_cnt - fe0 !== 1) begin
         miscompares++; $display("FAIL ferr_count: got %0d, required 1", fe_cnt - fe0);
      end
      vectors++;
      if (rx_if.DataOut !== 8'h5A) begin
         miscompares++; $display("FAIL ferr_dataout: got %h, required 5a", rx_if.DataOut);
      end
      vectors++;
      if (rx_if.busy !== 1'b1) begin
         miscompares++; $display("FAIL ferr_wait_busy: got %b, required 1", rx_if.busy);
      end
      idle_ticks(TPB);
      vectors++;
      if (rx_if.busy !== 1'b0) begin
         miscompares++; $display("FAIL ferr_idle_busy: got %b, required 0", rx_if.busy);
      end
      push_frame(8'h11, 1'b1, -1);
      play_all();
      idle_ticks(1);
      vectors++;
      if (rx_cnt - rx0 !== 2) begin
         miscompares++; $display("FAIL ferr_char_count: got %0d, required 2", rx_cnt - rx0);
      end
      vectors++;
      if (rx_if.DataOut !== 8'h11) begin
         miscompares++; $display("FAIL ferr_next_byte: got %h, required 11", rx_if.DataOut);
      end
      got_q.delete();
   endtask

   task automatic test_break();
      int rx0, fe0;
      rx0 = rx_cnt; fe0 = fe_cnt;
      push_frame(8'h00, 1'b0, -1);
      push_level(1'b0, TPB * 20);
      play_all();
      vectors++;
      if ((fe_cnt - fe0) !== 1 || (rx_cnt - rx0) !== 0) begin
         miscompares++;
         $display("FAIL break_pulses: got %0d ferr / %0d char, required 1 / 0", fe_cnt - fe0, rx_cnt - rx0);
      end
      vectors++;
      if (rx_if.busy !== 1'b1) begin
         miscompares++; $display("FAIL break_busy: got %b, required 1", rx_if.busy);
      end
      idle_ticks(TPB);
   endtask

   task automatic test_reset_mid_frame();
      int rx0;
      logic [7:0] g;
      rx0 = rx_cnt;
      got_q.delete();
      push_frame(8'hC3, 1'b1, -1);
      play_n(TPB * 5 + 8);
      wave_q.delete();
      apply_reset(3);
      vectors++;
      if (rx_if.DataOut !== 8'h00) begin
         miscompares++; $display("FAIL midrst_dataout: got %h, required 00", rx_if.DataOut);
      end
      vectors++;
      if (rx_if.busy !== 1'b0) begin
         miscompares++; $display("FAIL midrst_busy: got %b, required 0", rx_if.busy);
      end
      idle_ticks(TPB);
      push_frame(8'h7E, 1'b1, -1);
      play_all();
      idle_ticks(1);
      vectors++;
      if (rx_cnt - rx0 !== 1) begin
         miscompares++; $display("FAIL midrst_count: got %0d, required 1", rx_cnt - rx0);
      end
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++;
      if (g !== 8'h7E) begin
         miscompares++; $display("FAIL midrst_byte: got %h, required 7e", g);
      end
      got_q.delete();
   endtask

   task automatic test_glitch();
      int gseg;
      logic [7:0] want;
`ifdef RX_MAJORITY_EN
      gseg = 6;
`else
      gseg = 7;
`endif
      want = model_byte(8'h96, gseg);
      push_frame(8'h96, 1'b1, gseg);
      play_all();
      idle_ticks(1);
      vectors++;
      if (rx_if.DataOut !== want) begin
         miscompares++; $display("FAIL glitch_byte: got %h, required %h", rx_if.DataOut, want);
      end
      got_q.delete();
   endtask

   initial begin
      rx_if.DataIn = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_false_start();
      test_frame_error();
      test_break();
      test_reset_mid_frame();
      test_glitch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
